// File: rtl/ucaspian_packet_encoder.sv
// ucaspian_packet_encoder: arbitrates core status requests and serializes them as opcode-prefixed byte packets
// Ports: clk, reset (async active-low); clear_done/ack_sent, metric_value/metric_send/metric_overflow,
// time_current/time_update/time_sent, output_fire_addr/output_fire_waiting/output_fire_sent handshakes;
// tx_data/tx_valid/tx_ready byte stream toward the host FIFO; busy while a packet or metric is outstanding.
module ucaspian_packet_encoder #(
  parameter logic [7:0] OP_CLEAR  = 8'h01,
  parameter logic [7:0] OP_METRIC = 8'h02,
  parameter logic [7:0] OP_TIME   = 8'h03,
  parameter logic [7:0] OP_FIRE   = 8'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_done,
  output logic        ack_sent,
  input  logic [7:0]  metric_value,
  input  logic        metric_send,
  output logic        metric_overflow,
  input  logic [31:0] time_current,
  input  logic        time_update,
  output logic        time_sent,
  input  logic [7:0]  output_fire_addr,
  input  logic        output_fire_waiting,
  output logic        output_fire_sent,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  typedef enum logic [1:0] {K_CLEAR, K_METRIC, K_TIME, K_FIRE} kind_t;
  state_t      state;
  kind_t       kind;
  logic [39:0] shreg;
  logic [2:0]  cnt;
  logic        metric_pending;
  logic [7:0]  metric_reg;
  logic        load_metric;
  assign load_metric      = (state == IDLE) && !clear_done && metric_pending;
  assign tx_valid         = (state == SEND);
  assign tx_data          = shreg[39:32];
  assign ack_sent         = (state == DONE) && (kind == K_CLEAR);
  assign time_sent        = (state == DONE) && (kind == K_TIME);
  assign output_fire_sent = (state == DONE) && (kind == K_FIRE);
  assign busy             = (state != IDLE) || metric_pending;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      kind            <= K_CLEAR;
      shreg           <= '0;
      cnt             <= '0;
      metric_pending  <= 1'b0;
      metric_reg      <= '0;
      metric_overflow <= 1'b0;
    end else begin
      // a pulse landing while the pending value is being loaded refills the slot instead of overflowing
      if (metric_send && (!metric_pending || load_metric)) begin
        metric_reg     <= metric_value;
        metric_pending <= 1'b1;
      end else if (metric_send) begin
        metric_overflow <= 1'b1;
      end else if (load_metric) begin
        metric_pending <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (clear_done) begin
            kind  <= K_CLEAR;
            shreg <= {OP_CLEAR, 32'h0};
            cnt   <= 3'd1;
            state <= SEND;
          end else if (metric_pending) begin
            kind  <= K_METRIC;
            shreg <= {OP_METRIC, metric_reg, 24'h0};
            cnt   <= 3'd2;
            state <= SEND;
          end else if (time_update) begin
            kind  <= K_TIME;
            shreg <= {OP_TIME, time_current};
            cnt   <= 3'd5;
            state <= SEND;
          end else if (output_fire_waiting) begin
            kind  <= K_FIRE;
            shreg <= {OP_FIRE, output_fire_addr, 24'h0};
            cnt   <= 3'd2;
            state <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            shreg <= {shreg[31:0], 8'h0};
            cnt   <= cnt - 3'd1;
            state <= (cnt == 3'd1) ? DONE : SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ucaspian_packet_encoder.md
Name: ucaspian_packet_encoder

Overview:
- Host-bound end of the uCaspian core's status/result handshakes.
- Consumes the core's clear-done, metric, current-time and output-fire requests, and returns ack_sent, time_sent and output_fire_sent.
- Arbitrates among pending requests and serializes each as an opcode-prefixed byte packet onto a valid/ready byte stream feeding the UART/USB transmit FIFO.

Parameters:
- OP_CLEAR, 8'h01, opcode of the clear-acknowledge packet (1 byte total).
- OP_METRIC, 8'h02, opcode of the metric packet (2 bytes: op, value).
- OP_TIME, 8'h03, opcode of the time packet (5 bytes: op, time[31:24], [23:16], [15:8], [7:0]).
- OP_FIRE, 8'h04, opcode of the output-fire packet (2 bytes: op, addr).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- clear_done  in  1  level; held by core until ack_sent.
- ack_sent  out  1  one-cycle pulse: clear packet fully sent.
- metric_value  in  8  metric byte, valid only while metric_send=1.
- metric_send  in  1  one-cycle pulse from core.
- metric_overflow  out  1  sticky: a metric pulse was dropped.
- time_current  in  32  current core time.
- time_update  in  1  level; held until time_sent.
- time_sent  out  1  one-cycle pulse: time packet fully sent.
- output_fire_addr  in  8  output neuron address.
- output_fire_waiting  in  1  level; held until output_fire_sent.
- output_fire_sent  out  1  one-cycle pulse: fire packet fully sent.
- tx_data  out  8  outgoing byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready.
- busy  out  1  high in any state other than IDLE, or while a metric is pending.

Behaviour:
- Reset (reset=0, async): state IDLE; tx_valid=0; tx_data=0; ack_sent, time_sent, output_fire_sent, metric_overflow, busy all 0; metric pending flag and capture register cleared.
- Reset mid-packet aborts the packet immediately. No *_sent pulse is issued. Any partially sent bytes are not retracted.
- Metric capture: metric_send is a pulse, so it is latched in every state.
  - If no metric is pending: capture metric_value and set metric_pending.
  - If a metric is already pending: drop the new value and set metric_overflow (cleared only by reset).
  - A metric_send arriving in the same cycle the pending metric is loaded into the shifter is captured as new, not dropped.
- State IDLE, arbitration on the current-cycle inputs, fixed priority: clear_done > metric_pending > time_update > output_fire_waiting.
  - The winner's packet bytes are loaded into a 40-bit shift register, MSB byte first; the byte count (1/2/5/2) goes to a 3-bit counter.
  - The time packet snapshots time_current at load; later changes do not affect the packet in flight.
  - Loading a metric clears metric_pending.
  - Next state SEND. No winner: stay IDLE.
- State SEND:
  - tx_valid=1; tx_data = top byte. The first byte appears in the cycle after the IDLE decision (1-cycle request-to-valid latency).
  - tx_data is held stable while tx_valid && !tx_ready.
  - On each accept: shift left 8 bits and decrement the counter.
  - When the last byte is accepted: tx_valid=0 next cycle, go to DONE.
  - Back-to-back accepts give one byte per cycle.
- State DONE (exactly 1 cycle):
  - Assert the sent pulse matching the packet type: clear→ack_sent, time→time_sent, fire→output_fire_sent, metric→none. Then go to IDLE.
  - The core drops its level request on the edge ending DONE, so IDLE never re-sends the same request.
  - If the core re-asserts time_update in that same edge (new step), IDLE sends a fresh time packet with the new value. This is correct behaviour.
- Sources not selected keep their level requests and are serviced in later packets. No starvation guarantee beyond priority order.
- Pulses and tx signals are registered outputs, with no combinational path from inputs to outputs.

Test Plan:
- Fire only: output_fire_waiting=1, addr=8'h2A, tx_ready=1 → bytes 04,2A on consecutive cycles; output_fire_sent pulses once 1 cycle after 2A accepted; no second packet.
- Time snapshot + backpressure: time_update=1, time_current=32'h0000_0107, tx_ready toggling 1/0 → bytes 03,00,00,01,07, each held stable while stalled; time_current changed to 8 mid-packet does not alter bytes; one time_sent pulse.
- Priority: clear_done, metric pulse (value 8'h05), time_update (t=3) and fire (addr 8'h11) asserted together → packets in order 01 | 02,05 | 03,00,00,00,03 | 04,11; ack_sent, time_sent, output_fire_sent each pulse once.
- Metric overflow: two metric_send pulses (8'h0A, 8'h0B) while tx_ready=0 and a fire packet is in flight → only 02,0A emitted; metric_overflow=1 and sticky.
- Reset mid-packet: assert reset during byte 3 of a time packet → tx_valid=0 immediately, no time_sent, all outputs 0; after release with time_update still high, full 5-byte packet re-sent.
- Re-arm: time_update re-asserted in DONE cycle with new time 32'h9 → second packet 03,00,00,00,09 follows with 1 IDLE cycle gap.
